// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the main-memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        GAP
    } mem_state_t;

    localparam int LAT_CNT_BITS   = 4;
    localparam int DEF_DATA_BITS  = 32;
    localparam int DEF_BLOCK_BITS = 2;
    localparam int DEF_BLOCK_SIZE = 2 ** DEF_BLOCK_BITS;

    typedef logic [DEF_BLOCK_SIZE-1:0][DEF_DATA_BITS-1:0] block_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word store with one write port and a block-wide combinational read
module mem_array #(
    parameter int DATA_BITS        = 32,
    parameter int MEM_ADDRESS_BITS = 12,
    parameter int BLOCK_BITS       = 2,
    localparam int BLOCK_SIZE      = 2 ** BLOCK_BITS
) (
    input  logic                                  clk,
    input  logic                                  we,
    input  logic [MEM_ADDRESS_BITS-1:0]           waddr,
    input  logic [DATA_BITS-1:0]                  wdata,
    input  logic [MEM_ADDRESS_BITS-1:0]           rbase,
    output logic [BLOCK_SIZE-1:0][DATA_BITS-1:0]  rdata
);

    logic [DATA_BITS-1:0] mem [2**MEM_ADDRESS_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rbase is block-aligned, so base + i stays inside the block
    always_comb begin
        rdata = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            rdata[i] = mem[rbase + MEM_ADDRESS_BITS'(i)];
        end
    end

endmodule

// File: rtl/main_memory.sv
// rtl/main_memory.sv - fixed-latency block refill / word write-back responder below the cache
module main_memory
    import mem_pkg::*;
#(
    parameter int RAM_ADDRESS_BITS = 32,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2,
    parameter int MEM_ADDRESS_BITS = 12,
    parameter int LATENCY          = 3,
    localparam int BLOCK_SIZE      = 2 ** BLOCK_BITS
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [RAM_ADDRESS_BITS-1:0]           prop_address,
    input  logic                                  prop_read_en,
    input  logic [DATA_BITS-1:0]                  prop_write_data,
    input  logic                                  prop_write_en,
    output logic                                  ram_valid,
    output logic [BLOCK_SIZE-1:0][DATA_BITS-1:0]  ram_data
);

    mem_state_t                         state;
    logic [LAT_CNT_BITS-1:0]            lat_cnt;
    logic [RAM_ADDRESS_BITS-1:0]        addr_q;
    logic [DATA_BITS-1:0]               wdata_q;
    logic                               rd_q;
    logic                               wr_q;
    logic                               accept;
    logic                               mem_we;
    logic [MEM_ADDRESS_BITS-1:0]        rd_base;
    logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] rd_block;
    logic                               unused_bits;

    assign accept  = (state == IDLE) && (prop_read_en || prop_write_en);
    // The write commits on the acceptance edge, so a combined read sees the new word
    assign mem_we  = !reset && (state == IDLE) && prop_write_en;
    assign rd_base = {addr_q[MEM_ADDRESS_BITS-1:BLOCK_BITS], {BLOCK_BITS{1'b0}}};

    // Captured write fields and upper address bits are kept for observability only
    assign unused_bits = ^{wdata_q, wr_q, addr_q, prop_address};

    mem_array #(
        .DATA_BITS        (DATA_BITS),
        .MEM_ADDRESS_BITS (MEM_ADDRESS_BITS),
        .BLOCK_BITS       (BLOCK_BITS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prop_address[MEM_ADDRESS_BITS-1:0]),
        .wdata (prop_write_data),
        .rbase (rd_base),
        .rdata (rd_block)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            ram_valid <= 1'b0;
            ram_data  <= '0;
        end else begin
            ram_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= prop_address;
                        wdata_q <= prop_write_data;
                        rd_q    <= prop_read_en;
                        wr_q    <= prop_write_en;
                        lat_cnt <= LAT_CNT_BITS'(LATENCY - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (lat_cnt == '0) begin
                        state     <= RESP;
                        ram_valid <= 1'b1;
                        if (rd_q) begin
                            ram_data <= rd_block;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP:    state <= GAP;
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory.sv
// tb/tb_main_memory.sv - scoreboard bench for main_memory at latencies 3, 5 and 1
module tb_main_memory;
    import mem_pkg::*;

    typedef struct {
        int     cyc;
        block_t data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst3, rst5, rst1;
    logic [31:0] prop_address;
    logic        prop_read_en;
    logic [31:0] prop_write_data;
    logic        prop_write_en;
    logic        v3, v5, v1;
    block_t      d3, d5, d1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    main_memory #(.LATENCY(3)) dut3 (
        .clk(clk), .reset(rst3), .prop_address(prop_address), .prop_read_en(prop_read_en),
        .prop_write_data(prop_write_data), .prop_write_en(prop_write_en),
        .ram_valid(v3), .ram_data(d3));

    main_memory #(.LATENCY(5)) dut5 (
        .clk(clk), .reset(rst5), .prop_address(prop_address), .prop_read_en(prop_read_en),
        .prop_write_data(prop_write_data), .prop_write_en(prop_write_en),
        .ram_valid(v5), .ram_data(d5));

    main_memory #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(rst1), .prop_address(prop_address), .prop_read_en(prop_read_en),
        .prop_write_data(prop_write_data), .prop_write_en(prop_write_en),
        .ram_valid(v1), .ram_data(d1));

    task automatic chk_blk(input string name, input block_t act, input block_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mon(input int sel, input logic v, input block_t d);
        exp_t e;
        int   n;
        if (v === 1'b1) begin
            n = (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
            if (n == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse dut%0d: got ram_valid=1 at cycle %0d expected no pulse", sel, cyc);
            end else begin
                case (sel)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                chk_int($sformatf("pulse_cycle dut%0d", sel), cyc, e.cyc);
                chk_blk($sformatf("ram_data dut%0d", sel), d, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, v3, d3);
        mon(1, v5, d5);
        mon(2, v1, d1);
    end

    // Request is held through RESP and GAP, the way the cache overlaps its drop
    task automatic issue(input int sel, input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [31:0] wd, input block_t exp, input logic [31:0] addr2);
        exp_t e;
        int   lat;
        lat = (sel == 0) ? 3 : (sel == 1) ? 5 : 1;
        @(posedge clk); #1;
        prop_address    = addr;
        prop_read_en    = rd;
        prop_write_en   = wr;
        prop_write_data = wd;
        e.cyc  = cyc + 1 + lat;
        e.data = exp;
        case (sel)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        for (int k = 0; k < lat + 3; k++) begin
            @(posedge clk); #1;
            if (k == 1) prop_address = addr2;
        end
        prop_read_en  = 1'b0;
        prop_write_en = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst3 = 1'b1; rst5 = 1'b1; rst1 = 1'b1;
        prop_address = '0; prop_read_en = 1'b0; prop_write_data = '0; prop_write_en = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            dut3.u_array.mem[i] = '0;
            dut5.u_array.mem[i] = '0;
            dut1.u_array.mem[i] = '0;
        end

        repeat (2) @(posedge clk);
        #1 rst3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_int("idle_valid", int'(v3), 0);
            chk_blk("idle_data", d3, '0);
        end

        for (int i = 0; i < 4; i++) dut3.u_array.mem[16 + i] = 32'(i + 1);
        issue(0, 32'h12, 1'b1, 1'b0, 32'h0, {32'd4, 32'd3, 32'd2, 32'd1}, 32'h12);
        issue(0, 32'h10001, 1'b0, 1'b1, 32'haaaa, {32'd4, 32'd3, 32'd2, 32'd1}, 32'h10001);
        issue(0, 32'h0, 1'b1, 1'b0, 32'h0, {32'd0, 32'd0, 32'haaaa, 32'd0}, 32'h0);
        issue(0, 32'h21, 1'b1, 1'b1, 32'h55, {32'd0, 32'd0, 32'h55, 32'd0}, 32'h21);
        issue(0, 32'h12, 1'b1, 1'b0, 32'h0, {32'd4, 32'd3, 32'd2, 32'd1}, 32'h21);

        @(posedge clk); #1 rst3 = 1'b1;
        for (int i = 0; i < 4; i++) dut5.u_array.mem[16 + i] = 32'(i + 5);
        @(posedge clk); #1 rst5 = 1'b0;
        prop_address = 32'h10; prop_read_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst5 = 1'b1; prop_read_en = 1'b0;
        @(posedge clk); #1;
        rst5 = 1'b0;
        chk_int("reset_busy_valid", int'(v5), 0);
        chk_blk("reset_busy_data", d5, '0);
        repeat (10) @(posedge clk);
        issue(1, 32'h13, 1'b1, 1'b0, 32'h0, {32'd8, 32'd7, 32'd6, 32'd5}, 32'h13);

        @(posedge clk); #1 rst5 = 1'b1; rst1 = 1'b0;
        issue(2, 32'h21, 1'b1, 1'b1, 32'h77, {32'd0, 32'd0, 32'h77, 32'd0}, 32'h21);
        issue(2, 32'h23, 1'b0, 1'b1, 32'h99, {32'd0, 32'd0, 32'h77, 32'd0}, 32'h23);
        issue(2, 32'h20, 1'b1, 1'b0, 32'h0, {32'h99, 32'd0, 32'h77, 32'd0}, 32'h20);

        repeat (10) @(posedge clk);
        chk_int("pending_dut3", q0.size(), 0);
        chk_int("pending_dut5", q1.size(), 0);
        chk_int("pending_dut1", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
